// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline control slice: opcodes, forwarding
// selects, sequencer states and the pipeline-register control bundle.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_de_write;
    logic de_ex_write;
    logic ex_mem_write;
    logic if_de_flush;
    logic de_ex_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RESET  = '{pc_write: 1'b0, if_de_write: 1'b0, de_ex_write: 1'b0,
                                       ex_mem_write: 1'b0, if_de_flush: 1'b1, de_ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_RUN    = '{pc_write: 1'b1, if_de_write: 1'b1, de_ex_write: 1'b1,
                                       ex_mem_write: 1'b1, if_de_flush: 1'b0, de_ex_flush: 1'b0};
  localparam pipe_ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_de_write: 1'b0, de_ex_write: 1'b0,
                                       ex_mem_write: 1'b0, if_de_flush: 1'b0, de_ex_flush: 1'b0};
  localparam pipe_ctl_t CTL_REDIR  = '{pc_write: 1'b1, if_de_write: 1'b1, de_ex_write: 1'b1,
                                       ex_mem_write: 1'b1, if_de_flush: 1'b1, de_ex_flush: 1'b1};
  // Load-use bubble: hold PC and IF/DE, inject a bubble into DE/EX, let the load advance.
  localparam pipe_ctl_t CTL_LDUSE  = '{pc_write: 1'b0, if_de_write: 1'b0, de_ex_write: 1'b1,
                                       ex_mem_write: 1'b1, if_de_flush: 1'b0, de_ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_DRAIN  = '{pc_write: 1'b0, if_de_write: 1'b1, de_ex_write: 1'b1,
                                       ex_mem_write: 1'b1, if_de_flush: 1'b1, de_ex_flush: 1'b1};
  localparam pipe_ctl_t CTL_TRAP   = '{pc_write: 1'b1, if_de_write: 1'b1, de_ex_write: 1'b1,
                                       ex_mem_write: 1'b1, if_de_flush: 1'b1, de_ex_flush: 1'b1};

  // MEM result is younger than WB, so it wins; x0 is hard-wired and never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] mem_rd, input logic mem_we,
                                        input logic [4:0] wb_rd,  input logic wb_we);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/otter_pipe_ctrl_fwd.sv
// EX-stage operand forwarding select logic (purely combinational).
module otter_fwd_unit
  import otter_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_we_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  always_comb begin
    fwd_a_o = fwd_pick(ex_rs1_i, mem_rd_i, mem_we_i, wb_rd_i, wb_we_i);
    fwd_b_o = fwd_pick(ex_rs2_i, mem_rd_i, mem_we_i, wb_rd_i, wb_we_i);
  end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage OTTER: hazard priority,
// pipeline-register enables/flushes, forwarding and interrupt entry.
module otter_pipe_ctrl
  import otter_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  de_rs1_addr,
  input  logic        de_rs1_used,
  input  logic [4:0]  de_rs2_addr,
  input  logic        de_rs2_used,
  input  logic        de_valid,
  input  logic [31:0] de_pc,
  input  logic [31:0] if_pc,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_reg_write,
  input  logic        mem_stall,
  input  logic        INTR,
  input  logic        int_en,
  output logic        pc_write,
  output logic        if_de_write,
  output logic        de_ex_write,
  output logic        ex_mem_write,
  output logic        if_de_flush,
  output logic        de_ex_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        int_taken,
  output logic [31:0] epc,
  output logic [31:0] stall_cycles
);

  ctrl_state_t state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] stall_q, stall_d;
  logic [4:0]  ex_rs1_q, ex_rs1_d;
  logic [4:0]  ex_rs2_q, ex_rs2_d;
  pipe_ctl_t   ctl;
  logic        load_use;
  logic        int_req;
  logic [1:0]  fwd_a_raw, fwd_b_raw;

  assign load_use = ex_mem_read && ex_reg_write && (ex_rd_addr != 5'd0) &&
                    ((de_rs1_used && (de_rs1_addr == ex_rd_addr)) ||
                     (de_rs2_used && (de_rs2_addr == ex_rd_addr)));

  assign int_req = INTR && int_en && !mem_stall && !ex_redirect;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      epc_q       <= '0;
      stall_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      epc_q       <= epc_d;
      stall_q     <= stall_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    epc_d       = epc_q;
    case (state_q)
      RUN: begin
        if (int_req) begin
          state_d     = DRAIN;
          drain_cnt_d = 3'(DRAIN_CYCLES);
          epc_d       = de_valid ? de_pc : if_pc;
        end
      end
      DRAIN: begin
        // An older control transfer resolving in the drain window owns the return point.
        if (ex_redirect) begin
          epc_d = ex_target;
        end
        if (!mem_stall) begin
          drain_cnt_d = drain_cnt_q - 3'd1;
          if (drain_cnt_q <= 3'd1) begin
            state_d = TRAP;
          end
        end
      end
      TRAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctl       = CTL_RUN;
    int_taken = 1'b0;
    if (RESET) begin
      ctl = CTL_RESET;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            ctl = CTL_FREEZE;
          end else if (ex_redirect) begin
            ctl = CTL_REDIR;
          end else if (load_use) begin
            ctl = CTL_LDUSE;
          end else begin
            ctl = CTL_RUN;
          end
        end
        DRAIN: ctl = mem_stall ? CTL_FREEZE : CTL_DRAIN;
        TRAP: begin
          ctl       = CTL_TRAP;
          int_taken = 1'b1;
        end
        default: ctl = CTL_RESET;
      endcase
    end
  end

  // DE/EX copy of the source registers; a bubble or unused operand reads as x0.
  always_comb begin
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    if (ctl.de_ex_flush) begin
      ex_rs1_d = '0;
      ex_rs2_d = '0;
    end else if (ctl.de_ex_write) begin
      ex_rs1_d = de_rs1_used ? de_rs1_addr : 5'd0;
      ex_rs2_d = de_rs2_used ? de_rs2_addr : 5'd0;
    end
  end

  always_comb begin
    stall_d = ctl.pc_write ? stall_q : stall_q + 32'd1;
  end

  otter_fwd_unit u_fwd (
    .ex_rs1_i (ex_rs1_q),
    .ex_rs2_i (ex_rs2_q),
    .mem_rd_i (mem_rd_addr),
    .mem_we_i (mem_reg_write),
    .wb_rd_i  (wb_rd_addr),
    .wb_we_i  (wb_reg_write),
    .fwd_a_o  (fwd_a_raw),
    .fwd_b_o  (fwd_b_raw)
  );

  assign fwd_a_sel    = RESET ? 2'd0 : fwd_a_raw;
  assign fwd_b_sel    = RESET ? 2'd0 : fwd_b_raw;
  assign pc_write     = ctl.pc_write;
  assign if_de_write  = ctl.if_de_write;
  assign de_ex_write  = ctl.de_ex_write;
  assign ex_mem_write = ctl.ex_mem_write;
  assign if_de_flush  = ctl.if_de_flush;
  assign de_ex_flush  = ctl.de_ex_flush;
  assign epc          = epc_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Directed, table-driven bench for otter_pipe_ctrl with hand-computed expectations.
module tb_otter_pipe_ctrl;

  // {pc_write, if_de_write, de_ex_write, ex_mem_write, if_de_flush, de_ex_flush}
  localparam logic [5:0] E_RST = 6'b000011;
  localparam logic [5:0] E_RUN = 6'b111100;
  localparam logic [5:0] E_FRZ = 6'b000000;
  localparam logic [5:0] E_RED = 6'b111111;
  localparam logic [5:0] E_LDU = 6'b001101;
  localparam logic [5:0] E_DRN = 6'b011111;
  localparam logic [5:0] E_TRP = 6'b111111;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  de_rs1_addr, de_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic        de_rs1_used, de_rs2_used, de_valid;
  logic [31:0] de_pc, if_pc, ex_target;
  logic        ex_reg_write, ex_mem_read, ex_redirect, mem_reg_write, wb_reg_write;
  logic        mem_stall, INTR, int_en;
  logic        pc_write, if_de_write, de_ex_write, ex_mem_write, if_de_flush, de_ex_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        int_taken;
  logic [31:0] epc, stall_cycles;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_stall = '0;

  otter_pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .de_rs1_addr(de_rs1_addr), .de_rs1_used(de_rs1_used),
    .de_rs2_addr(de_rs2_addr), .de_rs2_used(de_rs2_used),
    .de_valid(de_valid), .de_pc(de_pc), .if_pc(if_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .mem_stall(mem_stall), .INTR(INTR), .int_en(int_en),
    .pc_write(pc_write), .if_de_write(if_de_write), .de_ex_write(de_ex_write),
    .ex_mem_write(ex_mem_write), .if_de_flush(if_de_flush), .de_ex_flush(de_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .int_taken(int_taken), .epc(epc), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] rs1;   logic u1;
    logic [4:0] rs2;   logic u2;
    logic [4:0] exrd;  logic exrw; logic exmr;
    logic       redir; logic mstall;
    logic [4:0] memrd; logic memrw;
    logic [4:0] wbrd;  logic wbrw;
    logic [5:0] ctl;   logic [1:0] fa; logic [1:0] fb;
  } vec_t;

  vec_t vecs[11];

  task automatic clr();
    RESET = 1'b0;
    de_rs1_addr = '0; de_rs1_used = 1'b0; de_rs2_addr = '0; de_rs2_used = 1'b0;
    de_valid = 1'b1; de_pc = '0; if_pc = '0;
    ex_rd_addr = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; ex_target = '0;
    mem_rd_addr = '0; mem_reg_write = 1'b0; wb_rd_addr = '0; wb_reg_write = 1'b0;
    mem_stall = 1'b0; INTR = 1'b0; int_en = 1'b0;
  endtask

  // Compare the combinational outputs for the inputs already applied, then step one clock.
  task automatic cyc(input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic it, input string name);
    logic [10:0] act, expv;
    #1;
    act  = {pc_write, if_de_write, de_ex_write, ex_mem_write, if_de_flush, de_ex_flush,
            fwd_a_sel, fwd_b_sel, int_taken};
    expv = {ctl, fa, fb, it};
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, act, expv);
    end
    if (RESET) exp_stall = '0;
    else if (!ctl[5]) exp_stall = exp_stall + 32'd1;
    @(negedge CLK);
  endtask

  task automatic chk32(input logic [31:0] act, input logic [31:0] expv, input string name);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, expv);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{5'd1,1'b1, 5'd2,1'b1, 5'd0,1'b0,1'b0, 1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, E_RUN,2'd0,2'd0};
    vecs[1]  = '{5'd3,1'b1, 5'd4,1'b1, 5'd0,1'b0,1'b0, 1'b0,1'b0, 5'd1,1'b1, 5'd2,1'b1, E_RUN,2'd1,2'd2};
    vecs[2]  = '{5'd0,1'b1, 5'd0,1'b1, 5'd0,1'b0,1'b0, 1'b0,1'b0, 5'd4,1'b1, 5'd4,1'b1, E_RUN,2'd0,2'd1};
    vecs[3]  = '{5'd7,1'b1, 5'd7,1'b1, 5'd0,1'b0,1'b0, 1'b0,1'b0, 5'd0,1'b1, 5'd0,1'b1, E_RUN,2'd0,2'd0};
    vecs[4]  = '{5'd5,1'b1, 5'd6,1'b1, 5'd9,1'b1,1'b1, 1'b0,1'b0, 5'd7,1'b0, 5'd7,1'b1, E_RUN,2'd2,2'd2};
    vecs[5]  = '{5'd1,1'b1, 5'd6,1'b1, 5'd6,1'b1,1'b1, 1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, E_LDU,2'd0,2'd0};
    vecs[6]  = '{5'd2,1'b1, 5'd6,1'b0, 5'd6,1'b1,1'b1, 1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, E_RUN,2'd0,2'd0};
    vecs[7]  = '{5'd3,1'b1, 5'd0,1'b0, 5'd3,1'b1,1'b1, 1'b1,1'b0, 5'd2,1'b1, 5'd0,1'b0, E_RED,2'd1,2'd0};
    vecs[8]  = '{5'd0,1'b1, 5'd0,1'b1, 5'd0,1'b1,1'b1, 1'b0,1'b0, 5'd0,1'b1, 5'd0,1'b0, E_RUN,2'd0,2'd0};
    vecs[9]  = '{5'd5,1'b1, 5'd0,1'b0, 5'd5,1'b1,1'b1, 1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, E_FRZ,2'd0,2'd0};
    vecs[10] = '{5'd5,1'b1, 5'd0,1'b0, 5'd5,1'b1,1'b1, 1'b1,1'b0, 5'd0,1'b0, 5'd0,1'b0, E_RED,2'd0,2'd0};

    clr();
    RESET = 1'b1;
    @(negedge CLK);
    cyc(E_RST, 2'd0, 2'd0, 1'b0, "reset0");
    RESET = 1'b1;
    cyc(E_RST, 2'd0, 2'd0, 1'b0, "reset1");
    clr();
    chk32(epc, 32'h0, "reset_epc");
    chk32(stall_cycles, 32'h0, "reset_stall");
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "first_run");

    for (int i = 0; i < 11; i++) begin
      clr();
      de_rs1_addr = vecs[i].rs1; de_rs1_used = vecs[i].u1;
      de_rs2_addr = vecs[i].rs2; de_rs2_used = vecs[i].u2;
      ex_rd_addr = vecs[i].exrd; ex_reg_write = vecs[i].exrw; ex_mem_read = vecs[i].exmr;
      ex_redirect = vecs[i].redir; mem_stall = vecs[i].mstall;
      mem_rd_addr = vecs[i].memrd; mem_reg_write = vecs[i].memrw;
      wb_rd_addr = vecs[i].wbrd; wb_reg_write = vecs[i].wbrw;
      cyc(vecs[i].ctl, vecs[i].fa, vecs[i].fb, 1'b0, $sformatf("vec%0d", i));
    end
    chk32(stall_cycles, exp_stall, "table_stall");

    // lw x5 in EX, consumer of x5 in DE
    clr(); de_rs1_addr = 5'd5; de_rs1_used = 1'b1;
    ex_rd_addr = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    cyc(E_LDU, 2'd0, 2'd0, 1'b0, "lu_bubble");
    clr(); de_rs1_addr = 5'd5; de_rs1_used = 1'b1; mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "lu_release");
    clr(); de_rs1_addr = 5'd8; de_rs1_used = 1'b1; wb_rd_addr = 5'd5; wb_reg_write = 1'b1;
    cyc(E_RUN, 2'd2, 2'd0, 1'b0, "lu_fwd_wb");
    chk32(stall_cycles, exp_stall, "lu_stall");

    // memory stall held over a pending redirect
    for (int i = 0; i < 4; i++) begin
      clr(); ex_redirect = 1'b1; ex_target = 32'h80; mem_stall = 1'b1;
      cyc(E_FRZ, 2'd0, 2'd0, 1'b0, $sformatf("ms_freeze%0d", i));
    end
    clr(); ex_redirect = 1'b1; ex_target = 32'h80;
    cyc(E_RED, 2'd0, 2'd0, 1'b0, "ms_redirect");
    chk32(stall_cycles, exp_stall, "ms_stall");

    // interrupt entry, epc from DE
    clr(); INTR = 1'b1; int_en = 1'b1; de_pc = 32'h100; if_pc = 32'h104;
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq_entry");
    for (int i = 0; i < 3; i++) begin
      clr();
      cyc(E_DRN, 2'd0, 2'd0, 1'b0, $sformatf("irq_drain%0d", i));
    end
    clr();
    chk32(epc, 32'h100, "irq_epc");
    cyc(E_TRP, 2'd0, 2'd0, 1'b1, "irq_trap");
    clr();
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq_after");
    chk32(stall_cycles, exp_stall, "irq_stall");

    // interrupt with older branch resolving in the first drain cycle
    clr(); INTR = 1'b1; int_en = 1'b1; de_pc = 32'h300;
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq2_entry");
    clr(); ex_redirect = 1'b1; ex_target = 32'h200;
    cyc(E_DRN, 2'd0, 2'd0, 1'b0, "irq2_drain0");
    clr(); cyc(E_DRN, 2'd0, 2'd0, 1'b0, "irq2_drain1");
    clr(); cyc(E_DRN, 2'd0, 2'd0, 1'b0, "irq2_drain2");
    clr();
    chk32(epc, 32'h200, "irq2_epc");
    cyc(E_TRP, 2'd0, 2'd0, 1'b1, "irq2_trap");

    // bubble in DE: epc from IF; reset in second drain cycle aborts the trap
    clr(); INTR = 1'b1; int_en = 1'b1; de_valid = 1'b0; de_pc = 32'h999; if_pc = 32'h440;
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq3_entry");
    clr(); cyc(E_DRN, 2'd0, 2'd0, 1'b0, "irq3_drain0");
    clr();
    chk32(epc, 32'h440, "irq3_epc_ifpc");
    RESET = 1'b1;
    cyc(E_RST, 2'd0, 2'd0, 1'b0, "irq3_reset");
    clr();
    chk32(epc, 32'h0, "irq3_epc_cleared");
    chk32(stall_cycles, 32'h0, "irq3_stall_cleared");
    cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq3_run0");
    clr(); cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq3_run1");
    clr(); cyc(E_RUN, 2'd0, 2'd0, 1'b0, "irq3_run2");
    chk32(stall_cycles, exp_stall, "final_stall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/otter_pipe_ctrl.md
Name: otter_pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage pipelined OTTER (IF, DE, EX, MEM, WB).
- Produces per-register write enables and flushes, and the EX operand forwarding selects.
- Stalls on load-use hazards and freezes the pipe while data memory is busy.
- Handles interrupt entry by draining in-flight instructions and capturing the precise return PC.
- Sits beside the top-level datapath and drives every pipeline-register enable/flush and the PC write.

Parameters:
DRAIN_CYCLES, 3, cycles needed for EX/MEM/WB contents to retire before trap entry (legal range 1..7).

Ports:
CLK  in  1  clock
RESET  in  1  reset
de_rs1_addr  in  5  rs1 of instruction in DE
de_rs1_used  in  1  DE instruction reads rs1
de_rs2_addr  in  5  rs2 of instruction in DE
de_rs2_used  in  1  DE instruction reads rs2
de_valid  in  1  DE holds a real instruction (not a bubble)
de_pc  in  32  PC of DE instruction
if_pc  in  32  current fetch PC
ex_rd_addr  in  5  rd of EX instruction
ex_reg_write  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  branch taken, JAL or JALR resolved in EX
ex_target  in  32  redirect target PC
mem_rd_addr  in  5  rd in MEM
mem_reg_write  in  1  MEM writes rd
wb_rd_addr  in  5  rd in WB
wb_reg_write  in  1  WB writes rd
mem_stall  in  1  data memory not ready; freeze
INTR  in  1  external interrupt, level
int_en  in  1  mstatus.MIE
pc_write  out  1  PC register enable
if_de_write  out  1  IF/DE enable
de_ex_write  out  1  DE/EX enable
ex_mem_write  out  1  EX/MEM enable
if_de_flush  out  1  IF/DE clear to bubble
de_ex_flush  out  1  DE/EX clear to bubble
fwd_a_sel  out  2  0=regfile, 1=EX/MEM result, 2=MEM/WB result
fwd_b_sel  out  2  same encoding for operand B
int_taken  out  1  one-cycle trap entry pulse
epc  out  32  captured return PC (to mepc)
stall_cycles  out  32  count of cycles with pc_write=0

Behaviour:
Clocking and reset:
- Single clock CLK; reset is synchronous and active-high on RESET.
- While RESET=1: state goes to RUN, epc=0, stall_cycles=0.
- Outputs during reset: pc_write=0, all *_write=0, both flushes=1, int_taken=0, fwd selects=0.
- RESET asserted mid-DRAIN or in TRAP aborts the sequence with no int_taken.

Forwarding (combinational, every cycle):
- fwd_a_sel=1 if mem_reg_write and mem_rd_addr!=0 and mem_rd_addr==DE/EX rs1 (registered copy held internally).
- Otherwise fwd_a_sel=2 if the same condition holds on the wb_* inputs. Otherwise 0.
- B uses rs2 identically. MEM has priority over WB. Register x0 is never forwarded.

RUN priority, highest first:
1. mem_stall: every write enable and flush = 0 (full freeze); any held redirect or hazard resolves after release.
2. ex_redirect: pc_write=1, if_de_flush=1, de_ex_flush=1, other enables=1.
3. Load-use: condition is ex_mem_read & ex_reg_write & ex_rd_addr!=0 & ((de_rs1_used & rs1 match) | (de_rs2_used & rs2 match)).
   - Response: pc_write=0, if_de_write=0, de_ex_flush=1, ex_mem_write=1.
   - Exactly one bubble per load-use pair.
4. Otherwise: all enables 1, flushes 0.

Interrupt FSM, states RUN, DRAIN, TRAP:
- RUN->DRAIN when INTR & int_en & !mem_stall & !ex_redirect.
  - On entry: epc <= de_valid ? de_pc : if_pc.
  - Internal counter <= DRAIN_CYCLES.
- DRAIN outputs: pc_write=0, if_de_flush=1, de_ex_flush=1, de_ex_write=1, ex_mem_write=1.
  - Counter decrements only when !mem_stall; while mem_stall=1, freeze rules apply.
  - If ex_redirect=1 during DRAIN, epc <= ex_target (the older branch wins).
  - DRAIN->TRAP when the counter reaches 0.
  - INTR deasserting during DRAIN does not cancel the sequence.
- TRAP (exactly 1 cycle): int_taken=1, pc_write=1 (external PC mux selects mtvec), if_de_flush=1, de_ex_flush=1. TRAP->RUN.
- The CSR block clears MIE on int_taken, so no re-entry occurs until software re-enables it.

Stall counter:
- stall_cycles increments on every non-reset cycle with pc_write=0.
- 32-bit; wraps from 0xFFFFFFFF to 0.

Decomposition:
- Shared package otter_pkg holds opcode_t, the fwd_sel_t enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2), and the ctrl_state_t enum (RUN, DRAIN, TRAP).
- One sub-module, otter_fwd_unit: purely combinational forwarding-select logic, instantiated once.
- The FSM, hazard priority logic and counters live in otter_pipe_ctrl.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd_addr=5), DE uses rs1=5 -> one cycle with pc_write=0, de_ex_flush=1; next cycle fwd_a_sel=2 for that instruction; stall_cycles increments by 1.
- Forward priority: mem_rd_addr=7 and wb_rd_addr=7, both writing, DE/EX rs2=7 -> fwd_b_sel=1. Same case with rd=0 -> fwd_b_sel=0.
- Redirect plus load-use in the same cycle -> flushes=1 and pc_write=1, no stall bubble.
- mem_stall held 4 cycles during ex_redirect -> all enables 0 for 4 cycles, then redirect flush on release; stall_cycles increments by 4.
- Interrupt: de_pc=0x100, de_valid=1, INTR=1, int_en=1 -> 3 DRAIN cycles, then int_taken pulse; epc=0x100. Repeat with ex_redirect in DRAIN cycle 1, ex_target=0x200 -> epc=0x200.
- RESET asserted in DRAIN cycle 2 -> state RUN, epc=0, no int_taken; stall_cycles=0.
